// File: rtl/sys_multi_timer_pkg.sv
// Shared register map and control-bit layout for the multi-channel interval timer.
package sys_multi_timer_pkg;

  typedef enum logic [2:0] {
    OFS_STATUS   = 3'd0,
    OFS_CONTROL  = 3'd1,
    OFS_PERIOD_L = 3'd2,
    OFS_PERIOD_H = 3'd3,
    OFS_SNAP_L   = 3'd4,
    OFS_SNAP_H   = 3'd5,
    OFS_PRESCALE = 3'd6,
    OFS_PENDING  = 3'd7
  } reg_ofs_e;

  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;

endpackage

// File: rtl/sys_multi_timer_if.sv
// Avalon-style slave bus bundle for the multi-channel timer.
interface sys_multi_timer_if #(
  parameter int ADDR_W = 4
) ();
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [15:0]       writedata;
  logic [15:0]       readdata;
  logic              irq;

  modport master (output address, chipselect, write_n, writedata,
                  input  readdata, irq);
  modport slave  (input  address, chipselect, write_n, writedata,
                  output readdata, irq);
endinterface

// File: rtl/sys_timer_channel.sv
// One timer channel: prescaler, down-counter, run control, snapshot and its register file.
module sys_timer_channel
  import sys_multi_timer_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int RESET_PERIOD = 49999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr,
  input  logic [2:0]  ofs,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        pend
);

  logic [CNT_W-1:0] period, counter, snapshot;
  logic [7:0]       prescale, pre_cnt;
  logic [3:0]       control;
  logic             running, timeout, force_reload, cnt_zero_p1;
  logic             wr_status, wr_ctrl, wr_per_l, wr_per_h, wr_snap, wr_prs;
  logic             start_stb, stop_stb, cnt_zero, tick, to_evt;

  assign wr_status = wr && (ofs == OFS_STATUS);
  assign wr_ctrl   = wr && (ofs == OFS_CONTROL);
  assign wr_per_l  = wr && (ofs == OFS_PERIOD_L);
  assign wr_per_h  = wr && (ofs == OFS_PERIOD_H);
  assign wr_snap   = wr && (ofs == OFS_SNAP_L || ofs == OFS_SNAP_H);
  assign wr_prs    = wr && (ofs == OFS_PRESCALE);

  assign start_stb = wr_ctrl && wdata[CTL_START];
  assign stop_stb  = wr_ctrl && wdata[CTL_STOP];
  assign cnt_zero  = (counter == '0);
  assign tick      = running && (pre_cnt == prescale);
  assign to_evt    = cnt_zero && !cnt_zero_p1;
  assign pend      = timeout && control[CTL_ITO];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period       <= CNT_W'(RESET_PERIOD);
      counter      <= CNT_W'(RESET_PERIOD);
      snapshot     <= '0;
      prescale     <= '0;
      pre_cnt      <= '0;
      control      <= '0;
      running      <= 1'b0;
      timeout      <= 1'b0;
      force_reload <= 1'b0;
      cnt_zero_p1  <= (RESET_PERIOD == 0);
    end else begin
      force_reload <= wr_per_l || wr_per_h;
      cnt_zero_p1  <= cnt_zero;
      if (wr_ctrl)  control              <= wdata[3:0];
      if (wr_per_l) period[15:0]         <= wdata;
      if (wr_per_h) period[CNT_W-1:16]   <= wdata[CNT_W-17:0];
      if (wr_prs)   prescale             <= wdata[7:0];
      if (wr_snap)  snapshot             <= counter;

      if (start_stb || force_reload) pre_cnt <= '0;
      else if (running)              pre_cnt <= tick ? 8'd0 : pre_cnt + 8'd1;

      // One-shot mode parks at zero; only continuous mode reloads from zero.
      if (force_reload)   counter <= period;
      else if (tick) begin
        if (!cnt_zero)              counter <= counter - 1'b1;
        else if (control[CTL_CONT]) counter <= period;
      end

      if (force_reload)                          running <= 1'b0;
      else if (start_stb)                        running <= 1'b1;
      else if (stop_stb)                         running <= 1'b0;
      else if (cnt_zero && !control[CTL_CONT])   running <= 1'b0;

      if (wr_status)   timeout <= 1'b0;
      else if (to_evt) timeout <= 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    case (ofs)
      OFS_STATUS:   rdata = {14'b0, running, timeout};
      OFS_CONTROL:  rdata = {12'b0, control};
      OFS_PERIOD_L: rdata = period[15:0];
      OFS_PERIOD_H: rdata = 16'(period[CNT_W-1:16]);
      OFS_SNAP_L:   rdata = snapshot[15:0];
      OFS_SNAP_H:   rdata = 16'(snapshot[CNT_W-1:16]);
      OFS_PRESCALE: rdata = {8'b0, prescale};
      default:      rdata = '0;
    endcase
  end

endmodule

// File: rtl/sys_multi_timer.sv
// Multi-channel interval timer: address decode, registered read mux and combined interrupt.
module sys_multi_timer
  import sys_multi_timer_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = 32,
  parameter int RESET_PERIOD = 49999
) (
  input  logic             clk,
  input  logic             reset_n,
  sys_multi_timer_if.slave bus
);

  localparam int ADDR_W = $clog2(NUM_CH) + 3;

  logic [ADDR_W-1:0] ch_sel;
  logic [2:0]        ofs;
  logic              wr_any;
  logic [15:0]       ch_rd [NUM_CH];
  logic [NUM_CH-1:0] pend_vec;
  logic [15:0]       rd_nxt, rdata_p1;

  assign ch_sel = bus.address >> 3;
  assign ofs    = bus.address[2:0];
  assign wr_any = bus.chipselect && !bus.write_n;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sys_timer_channel #(
      .CNT_W       (CNT_W),
      .RESET_PERIOD(RESET_PERIOD)
    ) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .wr     (wr_any && (ch_sel == ADDR_W'(g))),
      .ofs    (ofs),
      .wdata  (bus.writedata),
      .rdata  (ch_rd[g]),
      .pend   (pend_vec[g])
    );
  end

  // Unpopulated channel slots fall through to zero.
  always_comb begin
    rd_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == ADDR_W'(i))
        rd_nxt = (ofs == OFS_PENDING) ? 16'(pend_vec) : ch_rd[i];
    end
  end

  // Read data stage: sampled every cycle, independent of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdata_p1 <= '0;
    else          rdata_p1 <= rd_nxt;
  end

  assign bus.readdata = rdata_p1;
  assign bus.irq      = |pend_vec;

endmodule

// File: tb/tb_sys_multi_timer.sv
// Scoreboard bench for sys_multi_timer with three channels (one unpopulated slot above them).
module tb_sys_multi_timer;
  import sys_multi_timer_pkg::*;

  localparam int NCH = 3;
  localparam int AW  = $clog2(NCH) + 3;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;
  int   n_chk   = 0;
  int   n_pass  = 0;
  int   t0, at, s_edge;
  logic [31:0] snap_exp;

  logic [15:0] exp_q [$];
  string       tag_q [$];

  sys_multi_timer_if #(.ADDR_W(AW)) bus ();

  sys_multi_timer #(
    .NUM_CH      (NCH),
    .CNT_W       (32),
    .RESET_PERIOD(49999)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic bus_wr(input int ch, input int ofs, input logic [15:0] data);
    bus.address    = AW'(ch * 8 + ofs);
    bus.writedata  = data;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk); #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_rd(input int ch, input int ofs, input logic [15:0] exp, input string tag);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    bus.address    = AW'(ch * 8 + ofs);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    @(posedge clk); #1;
    bus.chipselect = 1'b0;
    check_val(tag_q.pop_front(), 32'(bus.readdata), 32'(exp_q.pop_front()));
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin @(posedge clk); #1; end
  endtask

  task automatic wait_irq(input int limit, output int seen);
    seen = -1;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (bus.irq) begin seen = cyc; break; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_irq", 32'(bus.irq), 0);
    check_val("rst_rdata", 32'(bus.readdata), 0);
    reset_n = 1'b1;
    idle(1);

    bus_rd(0, OFS_PERIOD_L, 16'hC34F, "ch0_perl_rst");
    bus_rd(0, OFS_PERIOD_H, 16'h0000, "ch0_perh_rst");
    bus_rd(0, OFS_STATUS,   16'h0000, "ch0_status_rst");
    bus_rd(0, OFS_CONTROL,  16'h0000, "ch0_ctrl_rst");
    bus_rd(1, OFS_PRESCALE, 16'h0000, "ch1_prs_rst");
    bus_rd(2, OFS_SNAP_L,   16'h0000, "ch2_snapl_rst");
    bus_rd(1, OFS_PENDING,  16'h0000, "pending_rst");
    check_val("irq_rst", 32'(bus.irq), 0);

    bus_wr(3, OFS_PERIOD_L, 16'h1234);
    bus_rd(3, OFS_PERIOD_L, 16'h0000, "ch3_unpop_rd");
    bus_rd(2, OFS_PERIOD_L, 16'hC34F, "ch2_perl_untouched");

    // ch1 continuous, period 9, no prescale: timeout every 10 clocks.
    bus_wr(1, OFS_PERIOD_L, 16'd9);
    bus_wr(1, OFS_PERIOD_H, 16'd0);
    bus_wr(1, OFS_PRESCALE, 16'd0);
    idle(2);
    bus_wr(1, OFS_CONTROL, 16'h0007);
    t0 = cyc;
    wait_irq(40, at);
    check_val("ch1_first_to_cyc", 32'(at - t0), 10);
    bus_rd(1, OFS_PENDING, 16'h0002, "ch1_pending");
    bus_rd(0, OFS_PENDING, 16'h0002, "pending_via_ch0");
    bus_rd(1, OFS_STATUS,  16'h0003, "ch1_status_to");
    bus_wr(1, OFS_STATUS, 16'h0000);
    check_val("ch1_irq_cleared", 32'(bus.irq), 0);
    wait_irq(20, at);
    check_val("ch1_second_to_cyc", 32'(at - t0), 20);
    bus_wr(1, OFS_STATUS, 16'h0000);
    check_val("ch1_irq_cleared2", 32'(bus.irq), 0);
    wait_until(t0 + 29);
    bus_wr(1, OFS_STATUS, 16'h0000);
    check_val("clear_wins_irq", 32'(bus.irq), 0);
    bus_rd(1, OFS_STATUS, 16'h0002, "clear_wins_status");
    wait_irq(20, at);
    check_val("ch1_fourth_to_cyc", 32'(at - t0), 40);
    bus_wr(1, OFS_CONTROL, 16'h0008);
    bus_wr(1, OFS_STATUS, 16'h0000);
    bus_rd(1, OFS_STATUS, 16'h0000, "ch1_stopped");

    // ch0 one-shot, period 4, prescale 2: four ticks of 3 clocks, then one clock for the edge.
    bus_wr(0, OFS_PERIOD_L, 16'd4);
    bus_wr(0, OFS_PERIOD_H, 16'd0);
    bus_wr(0, OFS_PRESCALE, 16'd2);
    idle(2);
    bus_wr(0, OFS_CONTROL, 16'h0005);
    t0 = cyc;
    wait_irq(40, at);
    check_val("ch0_oneshot_to_cyc", 32'(at - t0), 4 * 3 + 1);
    bus_rd(0, OFS_STATUS,  16'h0001, "ch0_oneshot_status");
    bus_rd(2, OFS_PENDING, 16'h0001, "ch0_pending");
    idle(5);
    bus_wr(0, OFS_SNAP_L, 16'h0000);
    bus_rd(0, OFS_SNAP_L, 16'h0000, "ch0_held_l");
    bus_rd(0, OFS_SNAP_H, 16'h0000, "ch0_held_h");
    bus_wr(0, OFS_STATUS, 16'h0000);

    // ch0 snapshot mid-count from period 0x1_0000.
    bus_wr(0, OFS_PERIOD_H, 16'd1);
    bus_wr(0, OFS_PERIOD_L, 16'd0);
    bus_wr(0, OFS_PRESCALE, 16'd0);
    idle(2);
    bus_wr(0, OFS_CONTROL, 16'h0006);
    t0 = cyc;
    wait_until(t0 + 99);
    bus_wr(0, OFS_SNAP_H, 16'h0000);
    s_edge   = cyc;
    snap_exp = 32'h0001_0000 - 32'(s_edge - 1 - t0);
    bus_rd(0, OFS_SNAP_L, snap_exp[15:0],  "snap_mid_l");
    bus_rd(0, OFS_SNAP_H, snap_exp[31:16], "snap_mid_h");
    bus_wr(0, OFS_PERIOD_H, 16'd2);
    idle(1);
    bus_wr(0, OFS_SNAP_L, 16'h0000);
    bus_rd(0, OFS_SNAP_L, 16'h0000, "reload_snap_l");
    bus_rd(0, OFS_SNAP_H, 16'h0002, "reload_snap_h");
    bus_rd(0, OFS_STATUS, 16'h0000, "reload_stops");

    bus_wr(2, OFS_CONTROL, 16'h000C);
    bus_rd(2, OFS_STATUS,  16'h0002, "start_wins");
    bus_rd(2, OFS_CONTROL, 16'h000C, "ctrl_readback");

    // Mid-count reset while ch1 is interrupting.
    bus_wr(1, OFS_CONTROL, 16'h0007);
    wait_irq(25, at);
    check_val("ch1_irq_before_rst", 32'(bus.irq), 1);
    bus.address = AW'(1 * 8 + OFS_PERIOD_L);
    idle(1);
    check_val("rd_without_cs", 32'(bus.readdata), 9);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("async_rst_irq", 32'(bus.irq), 0);
    check_val("async_rst_rdata", 32'(bus.readdata), 0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(1);
    bus_rd(1, OFS_PERIOD_L, 16'hC34F, "post_rst_ch1_perl");
    bus_rd(1, OFS_CONTROL,  16'h0000, "post_rst_ch1_ctrl");
    bus_rd(1, OFS_STATUS,   16'h0000, "post_rst_ch1_status");
    bus_rd(0, OFS_PERIOD_H, 16'h0000, "post_rst_ch0_perh");
    bus_rd(0, OFS_SNAP_L,   16'h0000, "post_rst_ch0_snapl");
    bus_rd(2, OFS_CONTROL,  16'h0000, "post_rst_ch2_ctrl");
    check_val("post_rst_irq", 32'(bus.irq), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
